// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: sequencer state
// encoding and the even/odd entry mapping used by pair accesses.
package regfile_pkg;

    // Clear sequencer states: CLEAR zeroes the array, READY serves traffic.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Widest address the pair helpers handle; callers cast to their width.
    localparam int unsigned RF_ADDR_MAX = 32;

    // Even entry of a register pair (holds the low half of pair data).
    function automatic logic [RF_ADDR_MAX-1:0] pair_even_addr(input logic [RF_ADDR_MAX-1:0] addr);
        return addr & ~RF_ADDR_MAX'(1);
    endfunction

    // Odd entry of a register pair (holds the high half of pair data).
    function automatic logic [RF_ADDR_MAX-1:0] pair_odd_addr(input logic [RF_ADDR_MAX-1:0] addr);
        return addr | RF_ADDR_MAX'(1);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero, holding
// busy high until the last entry is written, then parks in READY.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    // Pointer is one bit wider than the address so the terminal value
    // never aliases with entry 0 on wrap.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;

    // State and pointer registers; reset restarts the clear from entry 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and outputs: one zero-write per cycle while clearing.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_o     = 1'b0;
        clr_we_o   = 1'b0;
        clr_addr_o = ptr_q[ADDR_WIDTH-1:0];
        case (state_q)
            RF_CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/register_file_2r1w.sv
// Register file with two registered read ports and one write port. Both
// reads and writes support byte (single entry) and pair (even/odd entry)
// access; pair data places the odd entry in the high half. The array is
// zeroed by the clear sequencer after every reset.
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WRITE_FIRST = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    busy,
    input  logic                    we,
    input  logic                    wpair,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [2*DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0]   raddr_a,
    input  logic                    rpair_a,
    output logic [2*DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0]   raddr_b,
    input  logic                    rpair_b,
    output logic [2*DATA_WIDTH-1:0] data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    clr_we;
    logic [ADDR_WIDTH-1:0]   clr_addr;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   w_even, w_odd;
    logic [DATA_WIDTH-1:0]   w_lo, w_hi;

    logic [ADDR_WIDTH-1:0]   a_even, a_odd, b_even, b_odd;
    logic [2*DATA_WIDTH-1:0] data_a_d, data_a_q;
    logic [2*DATA_WIDTH-1:0] data_b_d, data_b_q;

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Write-port decode; user writes are dropped while the clear runs.
    always_comb begin
        wr_en  = we & ~busy;
        w_even = ADDR_WIDTH'(pair_even_addr(RF_ADDR_MAX'(waddr)));
        w_odd  = ADDR_WIDTH'(pair_odd_addr(RF_ADDR_MAX'(waddr)));
        w_lo   = data_in[DATA_WIDTH-1:0];
        w_hi   = data_in[2*DATA_WIDTH-1:DATA_WIDTH];
        a_even = ADDR_WIDTH'(pair_even_addr(RF_ADDR_MAX'(raddr_a)));
        a_odd  = ADDR_WIDTH'(pair_odd_addr(RF_ADDR_MAX'(raddr_a)));
        b_even = ADDR_WIDTH'(pair_even_addr(RF_ADDR_MAX'(raddr_b)));
        b_odd  = ADDR_WIDTH'(pair_odd_addr(RF_ADDR_MAX'(raddr_b)));
    end

    // Array write port: clear sequencer has priority over user writes.
    // No reset here so the array can map onto RAM/register resources.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            if (wpair) begin
                mem[w_even] <= w_lo;
                mem[w_odd]  <= w_hi;
            end else begin
                mem[waddr]  <= w_lo;
            end
        end
    end

    // One entry as seen by a read this cycle. Forwarding, when enabled, is
    // per entry so a pair read only picks up the half being written.
    function automatic logic [DATA_WIDTH-1:0] rd_entry(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = mem[addr];
        if (WRITE_FIRST != 0 && wr_en) begin
            if (wpair) begin
                if (addr == w_even) begin
                    val = w_lo;
                end else if (addr == w_odd) begin
                    val = w_hi;
                end
            end else if (addr == waddr) begin
                val = w_lo;
            end
        end
        return val;
    endfunction

    // Read data next-state for both ports; forced to zero while clearing.
    always_comb begin
        data_a_d = '0;
        data_b_d = '0;
        if (!busy) begin
            if (rpair_a) begin
                data_a_d = {rd_entry(a_odd), rd_entry(a_even)};
            end else begin
                data_a_d = {{DATA_WIDTH{1'b0}}, rd_entry(raddr_a)};
            end
            if (rpair_b) begin
                data_b_d = {rd_entry(b_odd), rd_entry(b_even)};
            end else begin
                data_b_d = {{DATA_WIDTH{1'b0}}, rd_entry(raddr_b)};
            end
        end
    end

    // Registered read outputs, cleared on reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: one instance read-first, one
// write-first, driven by identical stimulus and checked against a table of
// hand-computed results plus clear/reset sequences.
module tb_register_file_2r1w;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        we, wpair, rpair_a, rpair_b;
    logic [7:0]  waddr, raddr_a, raddr_b;
    logic [15:0] data_in;
    logic        busy0, busy1;
    logic [15:0] data_a0, data_b0, data_a1, data_b1;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WRITE_FIRST(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .busy(busy0), .we(we), .wpair(wpair),
        .waddr(waddr), .data_in(data_in), .raddr_a(raddr_a), .rpair_a(rpair_a),
        .data_a(data_a0), .raddr_b(raddr_b), .rpair_b(rpair_b), .data_b(data_b0)
    );

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WRITE_FIRST(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .busy(busy1), .we(we), .wpair(wpair),
        .waddr(waddr), .data_in(data_in), .raddr_a(raddr_a), .rpair_a(rpair_a),
        .data_a(data_a1), .raddr_b(raddr_b), .rpair_b(rpair_b), .data_b(data_b1)
    );

    typedef struct {
        logic        we;
        logic        wp;
        logic [7:0]  wa;
        logic [15:0] din;
        logic [7:0]  ra;
        logic        rpa;
        logic [7:0]  rb;
        logic        rpb;
        logic [15:0] ea0, eb0, ea1, eb1;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic w, input logic wp, input logic [7:0] wa,
                                input logic [15:0] d, input logic [7:0] ra, input logic rpa,
                                input logic [7:0] rb, input logic rpb,
                                input logic [15:0] ea0, input logic [15:0] eb0,
                                input logic [15:0] ea1, input logic [15:0] eb1);
        vec_t v;
        v.we = w; v.wp = wp; v.wa = wa; v.din = d;
        v.ra = ra; v.rpa = rpa; v.rb = rb; v.rpb = rpb;
        v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wpair = 1'b0; waddr = 8'h00; data_in = 16'h0000;
        raddr_a = 8'h00; rpair_a = 1'b0; raddr_b = 8'h00; rpair_b = 1'b0;
    endtask

    // Runs until both instances leave busy, hammering writes to entry 5
    // (which must be lost) and checking reads stay zero meanwhile.
    task automatic run_clear(input string tag);
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            we = 1'b1; wpair = 1'b0; waddr = 8'h05; data_in = 16'h00AA;
            raddr_a = 8'(c); rpair_a = 1'b0; raddr_b = 8'(c); rpair_b = 1'b1;
            tick();
            if ((data_a0 | data_b0 | data_a1 | data_b1) != 16'h0000) begin
                chk({tag, " read_while_busy"}, {data_a0, data_b0} | {data_a1, data_b1}, 32'h0);
            end
        end
        idle_inputs();
        chk({tag, " busy_cycles_wf0"}, n0, 256);
        chk({tag, " busy_cycles_wf1"}, n1, 256);
    endtask

    // Reads every entry byte-wise on A and pair-wise on B, expecting zero.
    task automatic sweep_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            raddr_a = 8'(i); rpair_a = 1'b0; raddr_b = 8'(i); rpair_b = 1'b1;
            tick();
            if ((data_a0 | data_b0 | data_a1 | data_b1) != 16'h0000) begin
                bad++;
                if (bad < 4) $display("FAIL %s addr %0d: got %h %h %h %h expected 0", tag, i,
                                      data_a0, data_b0, data_a1, data_b1);
            end
        end
        nvec++;
        if (bad != 0) nerr++;
        idle_inputs();
    endtask

    initial begin
        // {we, wpair, waddr, data_in, raddr_a, rpair_a, raddr_b, rpair_b,
        //  exp_a rd-first, exp_b rd-first, exp_a wr-first, exp_b wr-first}
        tbl[0]  = mk(1'b1, 1'b0, 8'h10, 16'h003C, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h10, 1'b0, 8'h10, 1'b1, 16'h003C, 16'h003C, 16'h003C, 16'h003C);
        tbl[2]  = mk(1'b1, 1'b1, 8'h21, 16'hBEEF, 8'h20, 1'b0, 8'h21, 1'b0, 16'h0000, 16'h0000, 16'h00EF, 16'h00BE);
        tbl[3]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h20, 1'b0, 8'h21, 1'b0, 16'h00EF, 16'h00BE, 16'h00EF, 16'h00BE);
        tbl[4]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h20, 1'b1, 8'h21, 1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        tbl[5]  = mk(1'b1, 1'b0, 8'h07, 16'h0011, 8'h10, 1'b1, 8'h10, 1'b0, 16'h003C, 16'h003C, 16'h003C, 16'h003C);
        tbl[6]  = mk(1'b1, 1'b0, 8'h07, 16'h0055, 8'h07, 1'b0, 8'h06, 1'b1, 16'h0011, 16'h1100, 16'h0055, 16'h5500);
        tbl[7]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h07, 1'b0, 8'h07, 1'b1, 16'h0055, 16'h5500, 16'h0055, 16'h5500);
        tbl[8]  = mk(1'b1, 1'b0, 8'h01, 16'h0077, 8'h01, 1'b0, 8'h01, 1'b0, 16'h0000, 16'h0000, 16'h0077, 16'h0077);
        tbl[9]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h01, 1'b0, 8'h01, 1'b0, 16'h0077, 16'h0077, 16'h0077, 16'h0077);
        tbl[10] = mk(1'b1, 1'b0, 8'h03, 16'h0099, 8'h00, 1'b0, 8'h02, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[11] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h02, 1'b1, 8'h03, 1'b0, 16'h9900, 16'h0099, 16'h9900, 16'h0099);
        tbl[12] = mk(1'b1, 1'b1, 8'h30, 16'h1234, 8'h30, 1'b1, 8'h31, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0012);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h05, 1'b0, 8'h04, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[14] = mk(1'b1, 1'b0, 8'h40, 16'hFF66, 8'h40, 1'b1, 8'h41, 1'b1, 16'h0000, 16'h0000, 16'h0066, 16'h0066);
        tbl[15] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h40, 1'b1, 8'h41, 1'b0, 16'h0066, 16'h0000, 16'h0066, 16'h0000);
        tbl[16] = mk(1'b1, 1'b1, 8'h07, 16'hA5C3, 8'h06, 1'b0, 8'h06, 1'b1, 16'h0000, 16'h5500, 16'h00C3, 16'hA5C3);
        tbl[17] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 8'h07, 1'b0, 8'h06, 1'b1, 16'h00A5, 16'hA5C3, 16'h00A5, 16'hA5C3);

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        chk("reset busy_wf0", busy0, 1);
        chk("reset busy_wf1", busy1, 1);
        chk("reset data_a_wf0", data_a0, 0);
        chk("reset data_b_wf0", data_b0, 0);
        chk("reset data_a_wf1", data_a1, 0);
        chk("reset data_b_wf1", data_b1, 0);

        reset_n = 1'b1;
        run_clear("clear1");
        sweep_zero("clear1 sweep");

        for (int k = 0; k < NV; k++) begin
            we = tbl[k].we; wpair = tbl[k].wp; waddr = tbl[k].wa; data_in = tbl[k].din;
            raddr_a = tbl[k].ra; rpair_a = tbl[k].rpa; raddr_b = tbl[k].rb; rpair_b = tbl[k].rpb;
            tick();
            chk($sformatf("vec%0d a_wf0", k), data_a0, tbl[k].ea0);
            chk($sformatf("vec%0d b_wf0", k), data_b0, tbl[k].eb0);
            chk($sformatf("vec%0d a_wf1", k), data_a1, tbl[k].ea1);
            chk($sformatf("vec%0d b_wf1", k), data_b1, tbl[k].eb1);
        end
        idle_inputs();

        // Reset from READY, then again partway through the clear (ptr=100).
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (100) tick();
        chk("midclear busy_wf0", busy0, 1);
        reset_n = 1'b0;
        repeat (2) tick();
        chk("midreset data_a_wf0", data_a0, 0);
        reset_n = 1'b1;
        run_clear("clear2");
        chk("ready busy_wf0", busy0, 0);
        chk("ready busy_wf1", busy1, 0);
        sweep_zero("clear2 sweep");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
